// File: rtl/pid_egress_sched_pkg.sv
// Shared widths, header field offsets, FSM encoding and queue entry layout
// for the egress scheduler.
package pid_sched_pkg;

   localparam int PID_W    = 9;
   localparam int LEN_W    = 8;
   localparam int HDR_W    = 512;
   localparam int LEN_LSB  = 0;
   localparam int PORT_LSB = 8;

   typedef enum logic [0:0] {
      SELECT = 1'b0,
      GAP    = 1'b1
   } state_t;

   typedef struct packed {
      logic [PID_W-1:0] pid;
      logic [LEN_W-1:0] len;
   } entry_t;

   localparam int ENTRY_W = PID_W + LEN_W;

endpackage

// File: rtl/pid_egress_sched_if.sv
// MMU-facing bundle of the egress scheduler: packet handles in, PID read
// requests and drop notifications out.
interface pid_egress_sched_if
   import pid_sched_pkg::*;
#(
   parameter int NUM_PORTS = 4
);
   localparam int PORT_W = $clog2(NUM_PORTS);

   logic                 in_valid_pid;
   logic [PID_W-1:0]     in_pid;
   logic [HDR_W-1:0]     in_header;
   logic [NUM_PORTS-1:0] in_port_pause;

   logic                 out_valid_pid;
   logic [PID_W-1:0]     out_pid;
   logic [LEN_W-1:0]     out_pid_valid_lenth;
   logic [PORT_W-1:0]    out_port;
   logic                 out_drop;
   logic [PID_W-1:0]     out_drop_pid;
   logic [15:0]          drop_count;

   // MMU / environment side
   modport master (
      output in_valid_pid, in_pid, in_header, in_port_pause,
      input  out_valid_pid, out_pid, out_pid_valid_lenth, out_port,
             out_drop, out_drop_pid, drop_count
   );

   // scheduler side
   modport slave (
      input  in_valid_pid, in_pid, in_header, in_port_pause,
      output out_valid_pid, out_pid, out_pid_valid_lenth, out_port,
             out_drop, out_drop_pid, drop_count
   );

endinterface

// File: rtl/pid_egress_sched_queue.sv
// Per-port synchronous FIFO with first-word-fall-through read data.
// Push on a full queue and pop on an empty queue are ignored.
module pid_queue #(
   parameter int WIDTH      = 17,
   parameter int DEPTH_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_BITS:0]   count
);
   localparam int DEPTH = 1 << DEPTH_BITS;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == {(DEPTH_BITS+1){1'b0}});
   assign full    = (count == (DEPTH_BITS+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // storage write; contents need no reset because count gates every read
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // pointers and occupancy; a simultaneous push and pop leaves count unchanged
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= {DEPTH_BITS{1'b0}};
         rd_ptr <= {DEPTH_BITS{1'b0}};
         count  <= {(DEPTH_BITS+1){1'b0}};
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + DEPTH_BITS'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + DEPTH_BITS'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (DEPTH_BITS+1)'(1);
            2'b01:   count <= count - (DEPTH_BITS+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pid_egress_sched.sv
// Egress scheduler: queues MMU packet handles per port, picks a port
// round-robin and issues PID read requests spaced by packet length so the
// MMU read-out of consecutive packets never overlaps.
module pid_egress_sched
   import pid_sched_pkg::*;
#(
   parameter int NUM_PORTS        = 4,
   parameter int QUEUE_DEPTH_BITS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   pid_egress_sched_if.slave      bus
);
   localparam int PORT_W = $clog2(NUM_PORTS);

   // enqueue decode
   logic [LEN_W-1:0]     in_len;
   logic [PORT_W-1:0]    in_port_sel;
   entry_t               in_entry;
   logic                 drop;
   logic                 push_ok;

   // queue array
   logic [NUM_PORTS-1:0] q_push, q_pop, q_empty, q_full, eligible;
   logic [ENTRY_W-1:0]   q_dout  [NUM_PORTS];
   logic [QUEUE_DEPTH_BITS:0] q_count [NUM_PORTS];
   logic [NUM_PORTS-1:0] count_unused;
   logic                 hdr_unused;

   // arbiter / FSM
   logic [PORT_W-1:0]    last_grant;
   logic [PORT_W-1:0]    grant;
   logic [PORT_W-1:0]    rr_idx;
   logic                 any_eligible;
   entry_t               sel_entry;
   state_t               state, next_state;
   logic [LEN_W-1:0]     gap_cnt, next_gap;
   logic                 issue;

   // registered outputs
   logic                 issue_valid;
   logic [PID_W-1:0]     issue_pid;
   logic [LEN_W-1:0]     issue_len;
   logic [PORT_W-1:0]    issue_port;
   logic                 drop_strobe;
   logic [PID_W-1:0]     drop_pid;
   logic [15:0]          drops;

   assign in_len      = bus.in_header[LEN_LSB +: LEN_W];
   assign in_port_sel = bus.in_header[PORT_LSB +: PORT_W];
   assign in_entry    = '{pid: bus.in_pid, len: in_len};
   // full is judged on pre-pop occupancy, so a full queue drops even when popped now
   assign drop        = bus.in_valid_pid & ((in_len == {LEN_W{1'b0}}) | q_full[in_port_sel]);
   assign push_ok     = bus.in_valid_pid & ~drop;
   assign hdr_unused  = ^{bus.in_header[HDR_W-1:PORT_LSB+PORT_W], count_unused};

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      assign q_push[g]       = push_ok && (in_port_sel == PORT_W'(g));
      assign q_pop[g]        = issue && (grant == PORT_W'(g));
      assign eligible[g]     = ~q_empty[g] & ~bus.in_port_pause[g];
      assign count_unused[g] = ^q_count[g];

      pid_queue #(
         .WIDTH      (ENTRY_W),
         .DEPTH_BITS (QUEUE_DEPTH_BITS)
      ) u_queue (
         .clk   (clk),
         .reset (reset),
         .push  (q_push[g]),
         .pop   (q_pop[g]),
         .din   (in_entry),
         .dout  (q_dout[g]),
         .empty (q_empty[g]),
         .full  (q_full[g]),
         .count (q_count[g])
      );
   end

   assign sel_entry = entry_t'(q_dout[grant]);

   // round-robin search starting one past the last granted port
   always_comb begin
      any_eligible = 1'b0;
      grant        = {PORT_W{1'b0}};
      rr_idx       = {PORT_W{1'b0}};
      for (int i = 0; i < NUM_PORTS; i++) begin
         rr_idx = last_grant + PORT_W'(1) + PORT_W'(i);
         if (!any_eligible && eligible[rr_idx]) begin
            any_eligible = 1'b1;
            grant        = rr_idx;
         end else begin
            any_eligible = any_eligible;
         end
      end
   end

   // FSM next state: issue in SELECT, then sit out len-1 cycles in GAP
   always_comb begin
      next_state = state;
      next_gap   = gap_cnt;
      issue      = 1'b0;
      case (state)
         SELECT: begin
            if (any_eligible) begin
               issue = 1'b1;
               if (sel_entry.len > LEN_W'(1)) begin
                  next_state = GAP;
                  next_gap   = sel_entry.len - LEN_W'(1);
               end else begin
                  next_state = SELECT;
               end
            end else begin
               next_state = SELECT;
            end
         end
         GAP: begin
            if (gap_cnt <= LEN_W'(1)) begin
               next_state = SELECT;
            end else begin
               next_gap = gap_cnt - LEN_W'(1);
            end
         end
         default: next_state = SELECT;
      endcase
   end

   // FSM state and gap counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= SELECT;
         gap_cnt <= {LEN_W{1'b0}};
      end else begin
         state   <= next_state;
         gap_cnt <= next_gap;
      end
   end

   // request, drop and arbiter-pointer registers; fields hold after strobes fall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_valid <= 1'b0;
         issue_pid   <= {PID_W{1'b0}};
         issue_len   <= {LEN_W{1'b0}};
         issue_port  <= {PORT_W{1'b0}};
         last_grant  <= PORT_W'(NUM_PORTS - 1);
         drop_strobe <= 1'b0;
         drop_pid    <= {PID_W{1'b0}};
         drops       <= 16'd0;
      end else begin
         issue_valid <= issue;
         drop_strobe <= drop;
         if (issue) begin
            issue_pid  <= sel_entry.pid;
            issue_len  <= sel_entry.len;
            issue_port <= grant;
            last_grant <= grant;
         end
         if (drop) begin
            drop_pid <= bus.in_pid;
            if (drops != 16'hFFFF) begin
               drops <= drops + 16'd1;
            end
         end
      end
   end

   assign bus.out_valid_pid       = issue_valid;
   assign bus.out_pid             = issue_pid;
   assign bus.out_pid_valid_lenth = issue_len;
   assign bus.out_port            = issue_port;
   assign bus.out_drop            = drop_strobe;
   assign bus.out_drop_pid        = drop_pid;
   assign bus.drop_count          = drops;

endmodule

// File: doc/pid_egress_sched.md
# pid_egress_sched

Egress scheduler directly downstream of the packet MMU. It consumes the MMU's per-packet handle (PID plus stored header) and queues the PID per egress port. It arbitrates round-robin across ports and issues PID read requests back into the MMU's PID input, paced so the MMU's packet read-out never overlaps.

## Interface
Parameters:
- NUM_PORTS, 4: egress ports; power of two, 2..8.
- QUEUE_DEPTH_BITS, 4: per-port queue depth is 2**QUEUE_DEPTH_BITS entries.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- in_valid_pid, input, 1: one-cycle strobe carrying a new stored packet from the MMU.
- in_pid, input, 9: MMU packet handle.
- in_header, input, 512: first packet word; [7:0] length in 512-bit words, [8+:log2(NUM_PORTS)] egress port.
- in_port_pause, input, NUM_PORTS: per-port pause; a paused port is skipped by the arbiter.
- out_valid_pid, output, 1: one-cycle request strobe to the MMU PID FIFO.
- out_pid, output, 9: PID to read out.
- out_pid_valid_lenth, output, 8: words to read out.
- out_port, output, log2(NUM_PORTS): port the request serves.
- out_drop, output, 1: one-cycle strobe; the arriving PID was discarded.
- out_drop_pid, output, 9: PID discarded; the owner reclaims it.
- drop_count, output, 16: saturating count of drops.

## Operation
- Enqueue: on in_valid_pid, the block extracts len = in_header[7:0] and port from the header.
  - If len == 0, or the port queue holds 2**QUEUE_DEPTH_BITS entries, the PID is dropped: out_drop/out_drop_pid next cycle and drop_count increments, saturating at 16'hFFFF.
  - Otherwise {pid, len} is pushed to that port's queue.
- Full check uses occupancy before any same-cycle pop. A full queue drops even if it is popped in the same cycle.
- Eligible port: queue non-empty and in_port_pause bit low.
- Arbiter: round-robin. Search starts at (last granted + 1) mod NUM_PORTS; after reset the search starts at port 0.
- FSM states:
  - SELECT: if any port is eligible, pop the winner, register out_* and out_valid_pid=1. Go to GAP with gap_cnt = len-1 when len > 1; stay in SELECT when len == 1. If no port is eligible, hold with out_valid_pid=0.
  - GAP: gap_cnt decrements each cycle; at 1 return to SELECT. No issue occurs in GAP.
- Pause only masks eligibility. It never aborts an issued request or a running GAP.
- Out-of-range fields cannot occur: the port field width equals log2(NUM_PORTS).

## Timing
- Reset values: out_valid_pid=0, out_pid=0, out_pid_valid_lenth=0, out_port=0, out_drop=0, out_drop_pid=0, drop_count=0. FSM=SELECT, all queues empty.
- Enqueue latency: a push at edge N is eligible for selection in the cycle after edge N. The earliest out_valid_pid is at edge N+1 when the block is idle.
- Issue spacing: consecutive out_valid_pid pulses are at least len cycles apart, where len is the earlier request's length. len=1 permits back-to-back pulses.
- out_* fields hold their last value after the strobe falls.
- Drop strobe: 1 cycle after the offending in_valid_pid.
- Simultaneous push and pop on one non-full queue: both occur, and the count is unchanged.
- Reset asserted mid-GAP or mid-enqueue: state clears immediately, the pending request is lost, and no strobe is emitted on the reset edge.

## Structure
- Package pid_sched_pkg holds:
  - PID_W=9 and LEN_W=8.
  - Header field offsets: LEN_LSB=0, PORT_LSB=8.
  - FSM state encoding: SELECT, GAP.
  - The {pid, len} entry typedef.
- Sub-module pid_queue: synchronous FIFO, width 17, depth 2**QUEUE_DEPTH_BITS, with push, pop, dout, empty, full and count ports. It is instantiated NUM_PORTS times.
- The top level holds the enqueue decode, the round-robin arbiter, the FSM/gap counter and the drop counter.

## Test plan
- Single packet: pid=5, port 2, len=3. Expect out_valid_pid one cycle later with out_pid=5, len=3, out_port=2; the next issue is no earlier than 3 cycles later.
- Round-robin: one entry each on ports 0..3, all len=1. Expect back-to-back issues on ports 0,1,2,3. A new port-1 entry after that is served before port 0.
- Overflow: 17 pushes to port 0 with QUEUE_DEPTH_BITS=4 while port 0 is paused. Expect the 17th to raise out_drop with its PID and drop_count=1.
- Zero length: header len=0, pid=9. Expect an out_drop with out_drop_pid=9 and no request.
- Pause: ports 0 and 1 loaded, port 0 paused. Expect only port 1 served; releasing the pause serves port 0.
- Reset during GAP: issue len=8, assert reset at gap cycle 3. Expect all outputs zero, queues empty, and no further strobes.
